// File: rtl/kmap_sweep_ctrl.sv
// Exhaustive 16-vector sweep of a 4-input function, sampled into a truth table and checked against a mask.
// Optional build macro MISMATCH_STOP_EN: end the sweep at the first mismatching vector.
module kmap_sweep_ctrl #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] exp_mask,
    input  logic        f_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        pass,
    output logic [4:0]  err_cnt,
    output logic [3:0]  err_idx
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t      state, state_n;
    logic [3:0]  idx, idx_n;
    logic [3:0]  cnt, cnt_n;
    logic [15:0] mask, mask_n;
    logic [15:0] result_n;
    logic [4:0]  err_cnt_n;
    logic [3:0]  err_idx_n;
    logic        pass_n;
    logic        miss;
    logic        stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= 4'd0;
            cnt     <= 4'd0;
            mask    <= 16'd0;
            result  <= 16'd0;
            err_cnt <= 5'd0;
            err_idx <= 4'd0;
            pass    <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            cnt     <= cnt_n;
            mask    <= mask_n;
            result  <= result_n;
            err_cnt <= err_cnt_n;
            err_idx <= err_idx_n;
            pass    <= pass_n;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        cnt_n     = cnt;
        mask_n    = mask;
        result_n  = result;
        err_cnt_n = err_cnt;
        err_idx_n = err_idx;
        pass_n    = pass;
        miss      = (f_in != mask[idx]);
`ifdef MISMATCH_STOP_EN
        stop      = miss || (idx == 4'd15);
`else
        stop      = (idx == 4'd15);
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n   = ST_SETTLE;
                    idx_n     = 4'd0;
                    cnt_n     = CNT_INIT;
                    mask_n    = exp_mask;
                    result_n  = 16'd0;
                    err_cnt_n = 5'd0;
                    err_idx_n = 4'd0;
                    pass_n    = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (cnt == 4'd0) state_n = ST_SAMPLE;
                else             cnt_n   = cnt - 4'd1;
            end
            ST_SAMPLE: begin
                result_n[idx] = f_in;
                if (miss) begin
                    err_cnt_n = err_cnt + 5'd1;
                    // err_cnt still zero means this is the first failing vector.
                    if (err_cnt == 5'd0) err_idx_n = idx;
                end
                if (stop) begin
                    state_n = ST_DONE;
                    pass_n  = (err_cnt_n == 5'd0);
                end else begin
                    state_n = ST_SETTLE;
                    idx_n   = idx + 4'd1;
                    cnt_n   = CNT_INIT;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    assign {a, b, c, d} = idx;
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE);

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// Directed bench for kmap_sweep_ctrl: SETTLE=2 main instance plus a SETTLE=1 instance.
module tb_kmap_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [15:0] exp_mask = 16'd0;
    logic        f_zero = 1'b0;
    logic        f_in, f_in2;
    logic        a, b, c, d, busy, done, pass;
    logic [15:0] result;
    logic [4:0]  err_cnt;
    logic [3:0]  err_idx;
    logic        a2, b2, c2, d2, busy2, done2, pass2;
    logic [15:0] result2;
    logic [4:0]  err_cnt2;
    logic [3:0]  err_idx2;

    int n_cmp = 0;
    int n_fail = 0;
    logic [29:0] exp_q[$];

    always #5 clk = ~clk;

    // Reference function f = a&b | c&d, optionally forced low.
    assign f_in  = f_zero ? 1'b0 : ((a & b) | (c & d));
    assign f_in2 = (a2 & b2) | (c2 & d2);

    kmap_sweep_ctrl #(.SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .exp_mask(exp_mask), .f_in(f_in),
        .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done), .result(result),
        .pass(pass), .err_cnt(err_cnt), .err_idx(err_idx)
    );

    kmap_sweep_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start2), .exp_mask(exp_mask), .f_in(f_in2),
        .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2), .result(result2),
        .pass(pass2), .err_cnt(err_cnt2), .err_idx(err_idx2)
    );

    function automatic logic [29:0] obs_pack();
        return {result, pass, err_cnt, err_idx, a, b, c, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic sweep(input logic [15:0] m, input logic fz, input logic [29:0] expv,
                         input int exp_cyc);
        int cyc;
        logic [29:0] e;
        exp_mask = m;
        f_zero   = fz;
        exp_q.push_back(expv);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; cyc = 1;
        chk("busy_c1", {31'd0, busy}, 32'd1);
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_cycle", cyc, exp_cyc);
        e = exp_q.pop_front();
        chk("sweep_result", {2'b0, obs_pack()}, {2'b0, e});
        chk("busy_in_done", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("idle_after", {30'd0, busy, done}, 32'd0);
        chk("hold_after", {2'b0, obs_pack()}, {2'b0, e});
    endtask

    initial begin
        int cyc;
        logic [29:0] e;

        // Reset state
        repeat (3) @(negedge clk);
        chk("in_reset", {busy, done, obs_pack()}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset", {busy, done, obs_pack()}, 32'd0);

        // Matching mask
        sweep(16'hF888, 1'b0, {16'hF888, 1'b1, 5'd0, 4'd0, 4'hF}, 49);

        // One-bit mask difference and an all-zero function
`ifdef MISMATCH_STOP_EN
        sweep(16'hF880, 1'b0, {16'h0008, 1'b0, 5'd1, 4'd3, 4'h3}, 13);
        sweep(16'hF888, 1'b1, {16'h0000, 1'b0, 5'd1, 4'd3, 4'h3}, 13);
`else
        sweep(16'hF880, 1'b0, {16'hF888, 1'b0, 5'd1, 4'd3, 4'hF}, 49);
        sweep(16'hF888, 1'b1, {16'h0000, 1'b0, 5'd7, 4'd3, 4'hF}, 49);
`endif

        // Start re-pulsed mid-sweep is ignored; reset mid-sweep aborts without done
        exp_mask = 16'hF888;
        f_zero   = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 2; k <= 30; k++) begin
            @(negedge clk);
            if (k == 20) start = 1'b1;
            if (k == 21) start = 1'b0;
            if (k == 22) chk("no_restart_vec", {28'd0, a, b, c, d}, 32'd7);
            if (k == 30) rst_n = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_reset", {busy, done, obs_pack()}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_reset_release", {busy, done, obs_pack()}, 32'd0);
        sweep(16'hF888, 1'b0, {16'hF888, 1'b1, 5'd0, 4'd0, 4'hF}, 49);

        // SETTLE=1 instance: vector steps every 2 cycles, done in cycle 33
        exp_mask = 16'hF888;
        exp_q.push_back({16'hF888, 1'b1, 5'd0, 4'd0, 4'hF});
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0; cyc = 1;
        for (int k = 0; k < 16; k++) begin
            chk("s1_vec", {28'd0, a2, b2, c2, d2}, k);
            @(negedge clk);
            @(negedge clk);
            cyc += 2;
        end
        while (done2 !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("s1_done_cycle", cyc, 33);
        e = exp_q.pop_front();
        chk("s1_result", {2'b0, result2, pass2, err_cnt2, err_idx2, a2, b2, c2, d2}, {2'b0, e});
        chk("s1_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
